// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, with busy status and a one-cycle done pulse.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic PAR_ODD = (PARITY == 2);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic ONE_STOP = (STOP_BITS == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shreg_d = data_in;
          par_d   = (^data_in) ^ PAR_ODD;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // shift keeps the next bit at position 0
            idx_d   = idx_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (ONE_STOP || stop_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four parameter sets at
// CLKS_PER_BIT=4 driven by hand-computed frames.
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] start_v = '0;
  logic [7:0] data_in = '0;
  logic       tx_w   [4];
  logic       busy_w [4];
  logic       done_w [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .data_in(data_in),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .data_in(data_in),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .data_in(data_in),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start_v[3]), .data_in(data_in),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int w, input logic [7:0] d);
    @(negedge clk);
    start_v[w] = 1'b1;
    data_in = d;
    @(posedge clk);
    #1 start_v[w] = 1'b0;
  endtask

  task automatic idle_watch(input int w, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_w[w] !== 1'b1 || busy_w[w] !== 1'b0 || done_w[w] !== 1'b0)
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Samples n cycles after the accept edge; bit i lands in got[i].
  task automatic frame(input int w, input int n, input logic [15:0] exp,
                       input string tag, input int inj,
                       input logic chain, input logic [7:0] cdat);
    logic [15:0] got = '0;
    logic first = 1'b0;
    int bsy = 0;
    int uns = 0;
    int both = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i % C == 0) first = tx_w[w];
      else if (tx_w[w] !== first) uns++;
      if (i % C == C / 2) got[i / C] = tx_w[w];
      if (busy_w[w] === 1'b1) bsy++;
      if (busy_w[w] === 1'b1 && done_w[w] === 1'b1) both++;
      if (i == inj) begin
        start_v[w] = 1'b1;
        data_in = 8'hFF;
      end else begin
        start_v[w] = 1'b0;
      end
    end
    chk({tag, "_bits"}, 32'(got), 32'(exp));
    chk({tag, "_stable"}, uns, 0);
    chk({tag, "_busy"}, bsy, n);
    chk({tag, "_both"}, both, 0);
    @(negedge clk);
    start_v[w] = 1'b0;
    chk({tag, "_done"}, {done_w[w], busy_w[w], tx_w[w]}, 3'b101);
    if (chain) begin
      start_v[w] = 1'b1;
      data_in = cdat;
      @(posedge clk);
      #1 start_v[w] = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, "_done1"}, {done_w[w], busy_w[w]}, 2'b00);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {tx_w[0], busy_w[0], done_w[0]}, 3'b100);
    reset_n = 1'b1;

    idle_watch(0, 20, "idle20");

    pulse(0, 8'h55);
    frame(0, 40, 16'h02AA, "f55", -1, 1'b0, 8'h00);

    pulse(1, 8'hA7);
    frame(1, 44, 16'h074E, "even_a7", -1, 1'b0, 8'h00);
    pulse(2, 8'hA7);
    frame(2, 44, 16'h054E, "odd_a7", -1, 1'b0, 8'h00);
    pulse(3, 8'hA7);
    frame(3, 48, 16'h0F4E, "stop2_a7", -1, 1'b0, 8'h00);

    pulse(0, 8'h55);
    frame(0, 40, 16'h02AA, "busy_ign", 10, 1'b0, 8'h00);
    idle_watch(0, 3 * C, "no_second");

    pulse(0, 8'h55);
    frame(0, 40, 16'h02AA, "chain_a", -1, 1'b1, 8'h00);
    frame(0, 40, 16'h0200, "chain_b", -1, 1'b0, 8'h00);

    pulse(0, 8'h55);
    repeat (17) @(negedge clk);
    chk("mid_busy", busy_w[0], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {tx_w[0], busy_w[0], done_w[0]}, 3'b100);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle_watch(0, 20, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the send-key single pulser.
- Accepts a one-cycle start pulse plus a parallel byte and emits one asynchronous serial UART frame on the tx line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing is produced by an internal baud counter.
- Reports busy status and a one-cycle done pulse to the surrounding transmitter logic.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request from the pulser; sampled only when busy=0
- data_in  input  8  byte to transmit; captured on the edge that accepts start
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse marking frame completion

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, done=0.
  - State IDLE; baud counter, bit index and shift register cleared.
  - No partial frame resumes after reset release.
- States: IDLE, START, DATA, PARITY, STOP. Every transition is registered.
- IDLE: tx=1, busy=0.
  - On an edge where start=1: latch data_in into the shift register, compute the parity bit from the latched byte, clear the baud counter, go to START, set busy=1, and drive tx=0 from that edge.
- Bit timing: every bit, including each stop bit, holds tx constant for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the bit on the terminal count.
- START: tx=0 for one bit time, then DATA.
- DATA: tx = data bit[idx], idx 0..7, LSB first.
  - After bit 7, go to PARITY if PARITY!=0, else STOP.
- PARITY: even mode tx = XOR of the 8 data bits; odd mode tx = inverted XOR. One bit time.
- STOP: tx=1 for STOP_BITS bit times.
- Frame length: N = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Completion: start accepted at edge k, so busy=1 from edge k to edge k+N.
  - At edge k+N: state returns to IDLE, busy=0, done=1 for exactly one cycle, tx stays 1.
- Start while busy=1: ignored, with no effect on the frame in progress or on the latched data. start is not queued.
- Start on the cycle done=1 (busy=0): accepted. The next start bit begins at that edge, giving back-to-back frames with no idle gap beyond the stop bit(s).
- data_in changes after the accept edge have no effect on the current frame.
- done and busy are never both 1.
- tx is never X after reset.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, no start for 20 cycles -> tx=1, busy=0, done=0 throughout.
2. Same config, start pulse with data_in=0x55 -> tx, in 4-cycle bits: 0,1,0,1,0,1,0,1,0,1; busy high for exactly 40 cycles; done=1 for one cycle at cycle 40.
3. PARITY=1, data 0xA7 (five ones) -> parity bit=1, frame 44 cycles. Repeat with PARITY=2 -> parity bit=0. STOP_BITS=2 -> frame 48 cycles with tx=1 for the last 8.
4. During a 0x55 frame, pulse start with data_in=0xFF at cycle 10 -> frame unchanged, still 0x55 bits, no second frame follows.
5. Start pulse coincident with done, data 0x00 -> second start bit begins immediately; second frame reads 0,0,0,0,0,0,0,0,0,1; total 80 busy+done-adjacent cycles with no idle bit between frames.
6. Assert reset_n low at cycle 17 of a frame (mid DATA) -> tx=1 and busy=0 asynchronously before the next clk edge. After release, tx stays 1 until a new start.
